// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and sign helper for the iterative divider.
package div_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned DREG_W = 64;
    localparam int unsigned WORK_W = 65;
    localparam int unsigned CNT_W  = 6;

    // Number of restoring steps before the result is ready.
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(REG_W);

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v, input logic neg);
        return neg ? REG_W'(~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/response bundle between EX (master) and the divider (slave).
interface div_if;
    import div_pkg::*;

    logic                   signed_div;
    logic [REG_W-1:0]       opdata1;
    logic [REG_W-1:0]       opdata2;
    logic                   start;
    logic                   annul;
    logic [DREG_W-1:0]      result;
    logic                   ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );

endinterface

// File: rtl/div.sv
// Iterative 32-bit radix-2 restoring divider; result = {remainder, quotient}.
module div
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);

    div_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [WORK_W-1:0]  work;
    logic [REG_W-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;

    logic [REG_W-1:0]   op1_mag;
    logic [REG_W-1:0]   op2_mag;
    logic [REG_W:0]     diff;

    // Operand magnitudes at accept time and the trial subtraction for one step.
    always_comb begin
        op1_mag = neg_if(bus.opdata1, bus.signed_div & bus.opdata1[REG_W-1]);
        op2_mag = neg_if(bus.opdata2, bus.signed_div & bus.opdata2[REG_W-1]);
        diff    = {1'b0, work[63:32]} - {1'b0, divisor};
    end

    // Divider FSM with registered result/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DIV_FREE;
            cnt        <= '0;
            work       <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.result <= '0;
            bus.ready  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    bus.ready  <= 1'b0;
                    bus.result <= '0;
                    if (bus.start && !bus.annul) begin
                        state   <= (bus.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
                        cnt     <= '0;
                        work    <= {32'b0, op1_mag, 1'b0};
                        divisor <= op2_mag;
                        neg_q   <= bus.signed_div & (bus.opdata1[REG_W-1] ^ bus.opdata2[REG_W-1]);
                        neg_r   <= bus.signed_div & bus.opdata1[REG_W-1];
                    end
                end
                DIV_BYZERO: begin
                    state      <= DIV_END;
                    bus.result <= '0;
                    bus.ready  <= 1'b1;
                end
                DIV_ON: begin
                    if (bus.annul || !bus.start) begin
                        state      <= DIV_FREE;
                        bus.ready  <= 1'b0;
                        bus.result <= '0;
                    end else if (cnt != STEPS) begin
                        // Negative trial: shift in 0; otherwise keep the difference and shift in 1.
                        work <= diff[REG_W] ? {work[63:0], 1'b0}
                                            : {diff[REG_W-1:0], work[31:0], 1'b1};
                        cnt  <= cnt + CNT_W'(1);
                    end else begin
                        bus.result <= {neg_if(work[64:33], neg_r), neg_if(work[31:0], neg_q)};
                        bus.ready  <= 1'b1;
                        state      <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (!bus.start) begin
                        state      <= DIV_FREE;
                        bus.ready  <= 1'b0;
                        bus.result <= '0;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider against an arithmetic reference.
module tb_div;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    div_if bus();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: divide magnitudes, then apply the sign rules; x/0 gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return 64'd0;
        ua = (s && a[31]) ? 32'(0 - a) : a;
        ub = (s && b[31]) ? 32'(0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (s && (a[31] != b[31])) q = 32'(0 - q);
        if (s && a[31])            r = 32'(0 - r);
        return {r, q};
    endfunction

    // Issue a request, hold start, scramble operands after accept; lat = edges until ready (-1 on timeout).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] res, output int lat);
        bit done;
        int i;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.signed_div = s;
        bus.start      = 1'b1;
        res  = '0;
        lat  = 0;
        done = 1'b0;
        i    = 0;
        while (!done && i < 100) begin
            @(posedge clk); #1;
            lat++;
            if (i == 0) begin
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = 1'($urandom_range(0, 1));
            end
            if (bus.ready) begin
                res  = bus.result;
                done = 1'b1;
            end
            i++;
        end
        if (!done) lat = -1;
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        total++;
        if (bus.result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        logic [63:0] res;
        int lat;
        do_div(32'd100, 32'd7, 1'b0, res, lat);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        total++;
        if (res !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", res, 64'h00000002_0000000E); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (bus.ready !== 1'b1 || bus.result !== 64'h00000002_0000000E) begin
                bad++; $display("FAIL divu_hold cyc=%0d ready=%b result=%h exp ready=1 result=%h", k, bus.ready, bus.result, 64'h00000002_0000000E);
            end
        end
        release_start();
        total++;
        if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
            bad++; $display("FAIL divu_release ready=%b result=%h exp 0/0", bus.ready, bus.result);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [63:0] te [3];
        logic [63:0] res;
        int lat;
        ta[0] = 32'hFFFFFFF9; tb[0] = 32'h2;        te[0] = 64'hFFFFFFFF_FFFFFFFD;
        ta[1] = 32'h7;        tb[1] = 32'hFFFFFFFE; te[1] = 64'h00000001_FFFFFFFD;
        ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF; te[2] = 64'h00000000_80000000;
        for (int k = 0; k < 3; k++) begin
            do_div(ta[k], tb[k], 1'b1, res, lat);
            total++;
            if (res !== te[k]) begin bad++; $display("FAIL signed_%0d got=%h exp=%h", k, res, te[k]); end
            total++;
            if (res !== ref_div(ta[k], tb[k], 1'b1)) begin bad++; $display("FAIL signed_model_%0d got=%h exp=%h", k, res, ref_div(ta[k], tb[k], 1'b1)); end
            total++;
            if (lat !== 34) begin bad++; $display("FAIL signed_latency_%0d got=%0d exp=34", k, lat); end
            release_start();
        end
    endtask

    task automatic test_byzero();
        logic [63:0] res;
        int lat;
        do_div(32'd5, 32'd0, 1'b1, res, lat);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL byzero_latency got=%0d exp=2", lat); end
        total++;
        if (res !== 64'd0) begin bad++; $display("FAIL byzero_result got=%h exp=0", res); end
        release_start();
        total++;
        if (bus.ready !== 1'b0) begin bad++; $display("FAIL byzero_release ready=%b exp=0", bus.ready); end
    endtask

    task automatic test_annul();
        logic [63:0] res;
        int lat;
        bit seen;
        bus.opdata1 = 32'hFFFFFFFF; bus.opdata2 = 32'h10; bus.signed_div = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        @(posedge clk); #1;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_ready seen=%b exp=0", seen); end
        do_div(32'hFFFFFFFF, 32'h10, 1'b0, res, lat);
        total++;
        if (res !== 64'h0000000F_0FFFFFFF) begin bad++; $display("FAIL annul_reissue got=%h exp=%h", res, 64'h0000000F_0FFFFFFF); end
        total++;
        if (lat !== 34) begin bad++; $display("FAIL annul_reissue_latency got=%0d exp=34", lat); end
        release_start();
    endtask

    task automatic test_start_drop();
        bit seen;
        bus.opdata1 = 32'h80000000; bus.opdata2 = 32'hFFFFFFFF; bus.signed_div = 1'b1; bus.start = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ready || bus.result != 64'd0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL start_drop_abort seen=%b exp=0", seen); end
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int lat;
        do_div(32'd1000, 32'd3, 1'b0, res, lat);
        total++;
        if (res !== ref_div(32'd1000, 32'd3, 1'b0)) begin bad++; $display("FAIL arst_pre got=%h exp=%h", res, ref_div(32'd1000, 32'd3, 1'b0)); end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
            bad++; $display("FAIL arst_end ready=%b result=%h exp 0/0", bus.ready, bus.result);
        end
        bus.start = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        bus.opdata1 = 32'd77; bus.opdata2 = 32'd5; bus.signed_div = 1'b0; bus.start = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.result !== 64'd0) begin
            bad++; $display("FAIL arst_on ready=%b result=%h exp 0/0", bus.ready, bus.result);
        end
        bus.start = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_div(32'd50, 32'd5, 1'b0, res, lat);
        total++;
        if (res !== 64'h00000000_0000000A || lat !== 34) begin
            bad++; $display("FAIL arst_recover got=%h lat=%0d exp=%h lat=34", res, lat, 64'h00000000_0000000A);
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int lat;
        logic [31:0] a, b;
        for (int k = 0; k < 3; k++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            do_div(a, b, 1'b0, res, lat);
            total++;
            if (res !== ref_div(a, b, 1'b0) || lat !== 34) begin
                bad++; $display("FAIL b2b_%0d got=%h lat=%0d exp=%h lat=34", k, res, lat, ref_div(a, b, 1'b0));
            end
            release_start();
            total++;
            if (bus.ready !== 1'b0) begin bad++; $display("FAIL b2b_free_%0d ready=%b exp=0", k, bus.ready); end
        end
    endtask

    task automatic test_random();
        logic [63:0] res, exp;
        int lat, exp_lat;
        logic [31:0] a, b;
        logic s;
        for (int k = 0; k < 30; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'(0 - $urandom_range(1, 20));
                default: b = $urandom;
            endcase
            exp     = ref_div(a, b, s);
            exp_lat = (b == 32'd0) ? 2 : 34;
            do_div(a, b, s, res, lat);
            total++;
            if (res !== exp) begin bad++; $display("FAIL rand_%0d a=%h b=%h s=%b got=%h exp=%h", k, a, b, s, res, exp); end
            total++;
            if (lat !== exp_lat) begin bad++; $display("FAIL rand_lat_%0d got=%0d exp=%0d", k, lat, exp_lat); end
            release_start();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.annul      = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_byzero();
        test_annul();
        test_start_drop();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
